rf_wport_arbiter: RTL

//  Shares the single register-file write port between the in-order writeback stage and
//  the long-latency (LL) unit (divider, slow loads). Pipe writes have priority. LL results

---
 rtl/rf_wport_arbiter_pkg.sv | 14 +
 rtl/rf_wb_fifo.sv | 50 +++++
 rtl/rf_wport_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared codes for the regfile write-port path: widths, write-enable codes,
// and the queued LL result entry.
package rf_wport_arbiter_pkg;
  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic REG_WRITE    = 1'b1;
  localparam logic REG_NO_WRITE = 1'b0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Small FIFO of LL writeback entries. The next-cycle empty/full flags are exported
// so the owner can register its handshake and stall outputs directly from them.
module rf_wb_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      empty_next,
  output logic      full_next
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;

  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign empty      = (count == '0);
  assign empty_next = (count_next == '0);
  assign full_next  = (count_next == CNT_W'(DEPTH));
  assign head       = mem[rd_ptr];

  // DEPTH is a power of 2, so pointer overflow is the wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single regfile write port between the writeback stage (priority)
// and queued long-latency results, with an age-driven stall to prevent LL starvation.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pipe_we,
  input  logic [RF_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  input  logic                 ll_valid,
  output logic                 ll_ready,
  input  logic [RF_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]      ll_data,
  output logic                 pipe_stall,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_data,
  output logic                 proto_err
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic             pipe_ok, head_ok, grant_head, push;
  logic             empty, empty_next, full_next;
  wb_entry_t        head, push_entry;
  logic [AGE_W-1:0] age, next_age;

  assign pipe_ok    = (pipe_we == REG_WRITE) && (pipe_rd != '0);
  assign head_ok    = !empty;
  assign grant_head = !pipe_ok && head_ok;
  // x0 results complete the handshake but never occupy a slot.
  assign push       = ll_valid && ll_ready && (ll_rd != '0);
  assign push_entry = '{rd: ll_rd, data: ll_data};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (grant_head),
    .head       (head),
    .empty      (empty),
    .empty_next (empty_next),
    .full_next  (full_next)
  );

  always_comb begin
    next_age = '0;
    if (!empty && !grant_head)
      next_age = (age >= AGE_W'(STARVE_LIMIT)) ? age : age + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      pipe_stall <= 1'b0;
      proto_err  <= 1'b0;
      ll_ready   <= 1'b0;
      age        <= '0;
    end else begin
      if (pipe_ok) begin
        rf_we   <= 1'b1;
        rf_rd   <= pipe_rd;
        rf_data <= pipe_data;
      end else if (head_ok) begin
        rf_we   <= 1'b1;
        rf_rd   <= head.rd;
        rf_data <= head.data;
      end else begin
        rf_we   <= 1'b0;
      end
      age        <= next_age;
      pipe_stall <= (next_age >= AGE_W'(STARVE_LIMIT)) && !empty_next;
      ll_ready   <= !full_next;
      if (pipe_we && pipe_stall) proto_err <= 1'b1;
    end
  end
endmodule
